// File: rtl/instr_fetch_unit.sv
// Program sequencer: owns the PC, fetches words over a req/valid handshake and
// presents each to the decoder for one accepted execute cycle.
module instr_fetch_unit #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int MCODE_W = 4,
  parameter int LUT_N   = 4,
  localparam int LUT_AW = $clog2(LUT_N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [PC_W-1:0]    prog_end,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [MCODE_W-1:0] mcode,
  output logic               instr_valid,
  input  logic               exec_stall,
  input  logic               branch,
  input  logic [LUT_AW-1:0]  jump_addr,
  input  logic               zeroflg,
  input  logic               sign,
  input  logic               carry,
  input  logic               overflow,
  input  logic               lut_we,
  input  logic [LUT_AW-1:0]  lut_waddr,
  input  logic [PC_W-1:0]    lut_wdata,
  output logic [PC_W-1:0]    pc,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  localparam logic [MCODE_W-1:0] OP_BZ  = MCODE_W'(4'b1011);
  localparam logic [MCODE_W-1:0] OP_BNN = MCODE_W'(4'b1100);
  localparam logic [MCODE_W-1:0] OP_BLE = MCODE_W'(4'b1101);

  state_t            state, state_d;
  logic [PC_W-1:0]   pc_d;
  logic [PC_W-1:0]   next_pc;
  logic              instr_ld;
  logic              cond;
  logic              taken;
  logic [PC_W-1:0]   lut [LUT_N];
  logic              unused_flags;

  assign unused_flags = carry ^ overflow;

  assign mcode       = instr[INSTR_W-1 -: MCODE_W];
  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == EXEC);
  assign done        = (state == DONE);

  always_comb begin
    state_d  = state;
    pc_d     = pc;
    instr_ld = 1'b0;
    cond     = 1'b1;
    taken    = 1'b0;
    next_pc  = pc + PC_W'(1);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: begin
        if (imem_valid) begin
          instr_ld = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (!exec_stall) begin
          case (mcode)
            OP_BZ:   cond = zeroflg;
            OP_BNN:  cond = ~sign;
            OP_BLE:  cond = sign | zeroflg;
            default: cond = 1'b1;
          endcase
          taken = branch & cond;
          if (taken) next_pc = lut[jump_addr];
          // A taken branch on the last instruction is still followed.
          if ((pc == prog_end) && !taken) begin
            state_d = DONE;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= '0;
      instr <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      if (instr_ld) instr <= imem_rdata;
    end
  end

  // Writes land at the edge, so a same-cycle read of that index sees the old target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised scoreboard bench for instr_fetch_unit: the driver predicts fetch
// addresses, executed words and completion; a negedge monitor checks them.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset_n, start;
  logic [9:0] prog_end;
  logic       imem_req, imem_valid;
  logic [9:0] imem_addr;
  logic [8:0] imem_rdata, instr;
  logic [3:0] mcode;
  logic       instr_valid, exec_stall, branch;
  logic [1:0] jump_addr;
  logic       zeroflg, sign, carry, overflow;
  logic       lut_we;
  logic [1:0] lut_waddr;
  logic [9:0] lut_wdata, pc;
  logic       done;

  instr_fetch_unit #(.PC_W(10), .INSTR_W(9), .MCODE_W(4), .LUT_N(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .prog_end(prog_end),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .instr(instr), .mcode(mcode), .instr_valid(instr_valid),
    .exec_stall(exec_stall), .branch(branch), .jump_addr(jump_addr),
    .zeroflg(zeroflg), .sign(sign), .carry(carry), .overflow(overflow),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;   // 0 fetch, 1 stalled exec, 2 accepted exec, 3 done
    logic [9:0] pc;
    logic [8:0] word;
  } ev_t;

  ev_t        sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [9:0] m_lut[4];
  logic [9:0] m_pc;
  bit         pw;
  logic [1:0] pwa;
  logic [9:0] pwd;
  logic       done_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic take(input logic [1:0] k, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_underflow: got no pending event, expected kind %0d (t=%0t)", k, $time);
    end else begin
      e  = sb.pop_front();
      ok = 1'b1;
      chk("event_kind", 32'(e.kind), 32'(k));
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (reset_n) begin
      if (imem_req && imem_valid) begin
        take(2'd0, e, ok);
        if (ok) chk("imem_addr", 32'(imem_addr), 32'(e.pc));
      end
      if (instr_valid) begin
        take(exec_stall ? 2'd1 : 2'd2, e, ok);
        if (ok) begin
          chk("instr", 32'(instr), 32'(e.word));
          chk("exec_pc", 32'(pc), 32'(e.pc));
          chk("mcode", 32'(mcode), 32'(e.word[8:5]));
        end
      end
      if (done && !done_q) begin
        take(2'd3, e, ok);
        if (ok) begin
          chk("done_pc", 32'(pc), 32'(e.pc));
          chk("done_iv", 32'(instr_valid), 32'(0));
        end
      end
    end
    done_q <= done;
  end

  // One clock: commit the model LUT write issued last cycle, then maybe issue another.
  task automatic tick();
    @(posedge clk);
    if (pw) m_lut[pwa] = pwd;
    #1;
    pw  = ($urandom_range(0, 5) == 0);
    pwa = 2'($urandom);
    pwd = ($urandom_range(0, 7) == 0) ? 10'h3FE + 10'($urandom_range(0, 1))
                                      : 10'($urandom_range(0, 7));
    lut_we    = pw;
    lut_waddr = pwa;
    lut_wdata = pwd;
  endtask

  function automatic logic [8:0] gen_word();
    logic [3:0] mc;
    case ($urandom_range(0, 3))
      0: mc = 4'b1011;
      1: mc = 4'b1100;
      2: mc = 4'b1101;
      default: mc = 4'($urandom);
    endcase
    return {mc, 5'($urandom)};
  endfunction

  task automatic run_prog(input logic [9:0] pe, input int rst_at, input bit from_done,
                          input int budget);
    int         steps = 0;
    int         lat, nst;
    logic [8:0] w;
    logic [3:0] mc;
    logic [1:0] ja;
    logic [9:0] nx;
    bit         br, z, s, cnd, tk;
    prog_end = pe;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_pc = '0;
    if (from_done) chk("done_clear", 32'(done), 32'(0));
    chk("start_req", 32'(imem_req), 32'(1));
    chk("start_pc", 32'(pc), 32'(0));
    forever begin
      if (steps == rst_at) begin
        imem_valid = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        pw = 1'b0;
        lut_we = 1'b0;
        for (int i = 0; i < 4; i++) m_lut[i] = '0;
        #1;
        chk("rst_req", 32'(imem_req), 32'(0));
        chk("rst_pc", 32'(pc), 32'(0));
        chk("rst_iv", 32'(instr_valid), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_instr", 32'(instr), 32'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;
        return;
      end
      lat = $urandom_range(1, 3);
      for (int c = 1; c < lat; c++) begin
        imem_valid = 1'b0;
        start = ($urandom_range(0, 3) == 0);
        tick();
      end
      chk("fetch_req", 32'(imem_req), 32'(1));
      if (!imem_req) return;
      w = gen_word();
      imem_valid = 1'b1;
      imem_rdata = w;
      sb.push_back('{kind: 2'd0, pc: m_pc, word: w});
      tick();
      imem_valid = 1'b0;
      start = 1'b0;
      chk("exec_iv", 32'(instr_valid), 32'(1));
      if (!instr_valid) return;
      nst = ($urandom_range(0, 3) == 0) ? 3 : $urandom_range(0, 1);
      for (int c = 0; c < nst; c++) begin
        exec_stall = 1'b1;
        branch = 1'($urandom);
        jump_addr = 2'($urandom);
        zeroflg = 1'($urandom);
        sign = 1'($urandom);
        imem_valid = 1'($urandom);
        imem_rdata = 9'($urandom);
        start = ($urandom_range(0, 3) == 0);
        sb.push_back('{kind: 2'd1, pc: m_pc, word: w});
        tick();
      end
      br = (steps < budget) ? ($urandom_range(0, 2) == 0) : 1'b0;
      ja = 2'($urandom);
      z  = 1'($urandom);
      s  = 1'($urandom);
      exec_stall = 1'b0;
      branch = br;
      jump_addr = ja;
      zeroflg = z;
      sign = s;
      carry = 1'($urandom);
      overflow = 1'($urandom);
      imem_valid = 1'($urandom);
      imem_rdata = 9'($urandom);
      start = 1'b0;
      mc = w[8:5];
      if (mc == 4'b1011)      cnd = z;
      else if (mc == 4'b1100) cnd = !s;
      else if (mc == 4'b1101) cnd = s || z;
      else                    cnd = 1'b1;
      tk = br && cnd;
      nx = tk ? m_lut[ja] : m_pc + 10'd1;
      sb.push_back('{kind: 2'd2, pc: m_pc, word: w});
      if (m_pc == pe && !tk) begin
        sb.push_back('{kind: 2'd3, pc: m_pc, word: '0});
        tick();
        imem_valid = 1'b0;
        for (int c = 0; c < $urandom_range(1, 3); c++) begin
          chk("done_hold", 32'(done), 32'(1));
          chk("done_noiv", 32'(instr_valid), 32'(0));
          tick();
        end
        return;
      end
      m_pc = nx;
      tick();
      steps++;
      if (steps > 500) begin
        chk("step_budget", 32'(steps), 32'(500));
        return;
      end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    start = 1'b0;
    prog_end = '0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    exec_stall = 1'b0;
    branch = 1'b0;
    jump_addr = '0;
    zeroflg = 1'b0;
    sign = 1'b0;
    carry = 1'b0;
    overflow = 1'b0;
    lut_we = 1'b0;
    lut_waddr = '0;
    lut_wdata = '0;
    pw = 1'b0;
    pwa = '0;
    pwd = '0;
    for (int i = 0; i < 4; i++) m_lut[i] = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("init_req", 32'(imem_req), 32'(0));
    chk("init_pc", 32'(pc), 32'(0));
    chk("init_iv", 32'(instr_valid), 32'(0));
    chk("init_done", 32'(done), 32'(0));
    chk("init_instr", 32'(instr), 32'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    run_prog(10'd3, -1, 1'b0, 0);
    run_prog(10'd9, 2, 1'b1, 0);
    for (int r = 0; r < 20; r++)
      run_prog(10'($urandom_range(4, 12)), -1, (r != 0), 30);

    tick();
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
